biu_bus_sequencer: RTL and testbench
====================================

Name: biu_bus_sequencer

Overview:
- Bus interface unit controller for the 16-bit CISC core.
- Owns the multiplexed AD bus and sequences it through T1-T4 bus cycles. Two requesters share the bus: the instruction prefetcher and execution-unit (EU) memory operands.
- Holds the 6-byte prefetch queue storage and occupancy state. Serves bytes to the decoder and flushes the queue on control transfer.

Parameters:
- QDEPTH, 6, prefetch queue depth in bytes (the pointer width must cover QDEPTH).
- RESET_PC, 16'hFFF0, fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ad_in  in  16  AD bus sampled value
- ad_out  out  16  AD bus drive value
- ad_oe  out  1  AD bus output enable
- ale  out  1  address latch enable
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- ready  in  1  memory ready; 0 inserts wait states
- eu_req  in  1  EU access request, held until eu_ack
- eu_we  in  1  1 = write, 0 = read
- eu_addr  in  16  EU word address, bit0 ignored
- eu_wdata  in  16  EU write data
- eu_ack  out  1  one-cycle pulse at EU cycle completion
- eu_rdata  out  16  EU read data, valid with eu_ack, held afterwards
- q_byte  out  8  queue head byte
- q_valid  out  1  queue non-empty
- q_pop  in  1  consume head byte
- flush  in  1  discard queue, restart fetch
- flush_addr  in  16  new fetch address

Behaviour:
Reset:
- Bus state IDLE; ad_oe=0, ale=0, rd_n=1, wr_n=1, ad_out=0.
- eu_ack=0, eu_rdata=0, queue empty, q_valid=0, q_byte=0.
- fetch_pc=RESET_PC.
- Asserting rst_n=0 mid-cycle aborts the cycle immediately; strobes return to inactive asynchronously.

FSM (IDLE, T1, T2, T3, T4), one state per clk:
- IDLE/T4 arbitration, evaluated on the clk edge that leaves IDLE or T4:
  - eu_req=1 -> T1 with EU cycle (EU priority).
  - else if free bytes >= 2, or fetch_pc odd and free >= 1 -> T1 with prefetch cycle.
  - else -> IDLE.
- T4 may go directly to T1; there are no idle cycles between back-to-back cycles.
- T1: ale=1, ad_oe=1, ad_out = {addr[15:1],1'b0}.
- T2, read: ad_oe=0, rd_n=0.
- T2, write: ad_oe=1, ad_out=eu_wdata, wr_n=0.
- T3: strobes held. If ready=0 the FSM stays in T3 (wait state). On an edge with ready=1 it moves to T4; read data is captured from ad_in on that edge.
- T4: strobes released, ad_oe=0. eu_ack=1 for EU cycles; eu_rdata updated on the T3->T4 edge.
- Cycle latency with no waits: eu_req sampled at IDLE -> eu_ack is high 4 cycles later (T1, T2, T3, T4).
- A prefetch cycle in progress is never preempted. eu_req arriving mid-cycle is served at the next T4 or IDLE decision.

Queue:
- Circular buffer of QDEPTH bytes with rd_ptr, wr_ptr and count; all wrap modulo QDEPTH.
- Prefetch completion with fetch_pc even: push lo byte then hi byte (count += 2), fetch_pc += 2.
- Prefetch completion with fetch_pc odd: push hi byte only (count += 1), fetch_pc += 1.
- q_byte = mem[rd_ptr] when count>0, else 0.
- q_pop with count=0 is ignored.
- Pop and push completing on the same edge: count = count + pushed - 1.

Flush:
- flush=1 on an edge: count=0, pointers=0, fetch_pc=flush_addr, q_valid=0 next cycle. flush has priority over a simultaneous q_pop and push.
- An in-flight prefetch cycle runs to T4 on the bus, but its data is discarded and fetch_pc is not advanced (the flush value stands).
- In-flight EU cycles are unaffected by flush.

Test Plan:
- Reset release, eu_req=0, ready=1 -> first T1 next edge with ad_out=16'hFFF0, ale=1. Three word fetches fill the queue to count 6 = bytes from FFF0..FFF5. The FSM then stays IDLE.
- Queue full, eu_req write addr 16'h1234, data 16'hBEEF -> T1 ad_out=1234, T2 ad_out=BEEF with wr_n=0, eu_ack pulses in T4, 4 cycles after request.
- EU read with ready=0 for 3 cycles in T3, ad_in=16'hA5A5 -> three wait states; eu_rdata=A5A5 with eu_ack on cycle 7; rd_n low from T2 until T4.
- eu_req raised during prefetch T2 -> prefetch completes, EU T1 follows directly after prefetch T4, no IDLE gap.
- flush with flush_addr=16'h2001 during prefetch T3 -> queue empty next cycle, fetched data dropped. Next prefetch addresses 2000 and pushes only the hi byte; the fetch after that is at 2002.
- q_pop and prefetch push on the same edge at count 3 -> count 4. q_pop at count 0 -> count stays 0, no pointer movement.

Source files
------------

// File: rtl/biu_bus_sequencer.sv
// Bus interface unit: sequences the multiplexed AD bus through T1-T4 cycles for
// the EU and the prefetcher, and owns the byte-wide prefetch queue.
module biu_bus_sequencer #(
  parameter int          QDEPTH   = 6,
  parameter logic [15:0] RESET_PC = 16'hFFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        ready,
  input  logic        eu_req,
  input  logic        eu_we,
  input  logic [15:0] eu_addr,
  input  logic [15:0] eu_wdata,
  output logic        eu_ack,
  output logic [15:0] eu_rdata,
  output logic [7:0]  q_byte,
  output logic        q_valid,
  input  logic        q_pop,
  input  logic        flush,
  input  logic [15:0] flush_addr
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  state_t          state, state_nx;
  logic            cyc_eu, cyc_we, drop;
  logic [15:0]     cyc_addr, cyc_wdata;
  logic [15:0]     fetch_pc;
  logic [7:0]      mem [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, free_b, push_n;
  logic            arb, start_eu, start_pf, start;
  logic            capture, push, push_two, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration happens only on edges leaving IDLE or T4; EU has priority.
  assign free_b   = CW'(QDEPTH) - count;
  assign arb      = (state == IDLE) || (state == T4);
  assign start_eu = arb && eu_req;
  assign start_pf = arb && !eu_req &&
                    ((free_b >= CW'(2)) || (fetch_pc[0] && (free_b >= CW'(1))));
  assign start    = start_eu || start_pf;

  assign capture  = (state == T3) && ready;
  // A flushed prefetch still completes on the bus but never reaches the queue.
  assign push     = capture && !cyc_eu && !drop && !flush;
  assign push_two = !cyc_addr[0];
  assign push_n   = push ? (push_two ? CW'(2) : CW'(1)) : '0;
  assign pop_ok   = q_pop && (count != '0);

  always_comb begin
    state_nx = state;
    ad_out   = 16'h0000;
    ad_oe    = 1'b0;
    ale      = 1'b0;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    eu_ack   = 1'b0;
    case (state)
      IDLE: if (start) state_nx = T1;
      T1: begin
        ale      = 1'b1;
        ad_oe    = 1'b1;
        ad_out   = {cyc_addr[15:1], 1'b0};
        state_nx = T2;
      end
      T2, T3: begin
        if (cyc_we) begin
          ad_oe  = 1'b1;
          ad_out = cyc_wdata;
          wr_n   = 1'b0;
        end else begin
          rd_n   = 1'b0;
        end
        state_nx = (state == T2) ? T3 : (ready ? T4 : T3);
      end
      T4: begin
        eu_ack   = cyc_eu;
        state_nx = start ? T1 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc_eu   <= 1'b0;
      cyc_we   <= 1'b0;
      drop     <= 1'b0;
      eu_rdata <= 16'h0000;
    end else begin
      state <= state_nx;
      if (start) begin
        cyc_eu <= start_eu;
        cyc_we <= start_eu && eu_we;
      end
      if (flush)      drop <= 1'b1;
      else if (start) drop <= 1'b0;
      if (capture && cyc_eu && !cyc_we) eu_rdata <= ad_in;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cyc_addr  <= start_eu ? eu_addr : fetch_pc;
      cyc_wdata <= eu_wdata;
    end
  end

  // Queue bookkeeping; flush overrides both push and pop on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= flush_addr;
    end else begin
      if (push) begin
        wr_ptr   <= push_two ? ptr_inc(ptr_inc(wr_ptr)) : ptr_inc(wr_ptr);
        fetch_pc <= fetch_pc + (push_two ? 16'd2 : 16'd1);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + push_n - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (push_two) begin
        mem[wr_ptr]          <= ad_in[7:0];
        mem[ptr_inc(wr_ptr)] <= ad_in[15:8];
      end else begin
        mem[wr_ptr]          <= ad_in[15:8];
      end
    end
  end

  assign q_valid = (count != '0);
  assign q_byte  = q_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_biu_bus_sequencer.sv
// Self-checking bench for biu_bus_sequencer: memory responder plus byte/EU
// scoreboards fed from the expected fetch stream.
module tb_biu_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ad_in, ad_out, eu_addr, eu_wdata, eu_rdata, flush_addr;
  logic        ad_oe, ale, rd_n, wr_n, ready, eu_req, eu_we, eu_ack;
  logic [7:0]  q_byte;
  logic        q_valid, q_pop, flush;

  logic [15:0] lat_addr = 16'h0000;
  logic        rd_override = 1'b0;
  logic [7:0]  exp_q [$];
  logic [15:0] eu_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  biu_bus_sequencer #(.QDEPTH(6), .RESET_PC(16'hFFF0)) dut (
    .clk(clk), .rst_n(rst_n), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .ready(ready), .eu_req(eu_req),
    .eu_we(eu_we), .eu_addr(eu_addr), .eu_wdata(eu_wdata), .eu_ack(eu_ack),
    .eu_rdata(eu_rdata), .q_byte(q_byte), .q_valid(q_valid), .q_pop(q_pop),
    .flush(flush), .flush_addr(flush_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return {byte_of({a[15:1], 1'b1}), byte_of({a[15:1], 1'b0})};
  endfunction

  // Memory model: address latched on ALE, data returned from the byte pattern.
  always @(posedge clk) if (ale) lat_addr <= ad_out;
  assign ad_in = rd_override ? 16'hA5A5 : word_at(lat_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] a);
    exp_q.push_back(byte_of(a));
    if (!a[0]) exp_q.push_back(byte_of(a + 16'd1));
  endtask

  task automatic pop_check(input string tag);
    check_eq({tag, "_valid"}, q_valid, 1'b1);
    if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 0, 1);
    else check_eq({tag, "_byte"}, q_byte, exp_q.pop_front());
    q_pop = 1'b1;
    tick();
    q_pop = 1'b0;
  endtask

  task automatic wait_ale(input string tag, input int max);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!ale && k < max);
    check_eq({tag, "_ale_seen"}, ale, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n_ale, k;
    rst_n = 1'b0; ready = 1'b1; eu_req = 1'b0; eu_we = 1'b0; eu_addr = '0;
    eu_wdata = '0; q_pop = 1'b0; flush = 1'b0; flush_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", {ad_oe, ale, rd_n, wr_n, eu_ack, q_valid}, 6'b001100);
    check_eq("rst_ad_out", ad_out, 16'h0000);
    check_eq("rst_rdata", eu_rdata, 16'h0000);
    check_eq("rst_qbyte", q_byte, 8'h00);
    rst_n = 1'b1;

    // Initial fill: three word fetches from the reset PC, then idle.
    tick();
    check_eq("t1_ale", ale, 1'b1);
    check_eq("t1_addr", ad_out, 16'hFFF0);
    push_word(16'hFFF0); push_word(16'hFFF2); push_word(16'hFFF4);
    n_ale = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ale) n_ale++;
    end
    check_eq("fill_ale_cnt", n_ale, 2);
    check_eq("fill_idle", {ale, rd_n, wr_n, ad_oe}, 4'b0110);
    check_eq("fill_head", q_byte, exp_q[0]);

    // EU write while queue is full.
    eu_req = 1'b1; eu_we = 1'b1; eu_addr = 16'h1234; eu_wdata = 16'hBEEF;
    tick();
    check_eq("wr_t1", {ale, ad_oe, ad_out}, {2'b11, 16'h1234});
    tick();
    check_eq("wr_t2", {ad_oe, wr_n, ad_out}, {2'b10, 16'hBEEF});
    tick();
    check_eq("wr_t3", {eu_ack, wr_n}, 2'b00);
    tick();
    check_eq("wr_t4", {eu_ack, wr_n}, 2'b11);
    eu_req = 1'b0;
    tick();
    check_eq("wr_ack_pulse", eu_ack, 1'b0);

    // EU read with three wait states.
    eu_req = 1'b1; eu_we = 1'b0; eu_addr = 16'h4567; rd_override = 1'b1;
    eu_q.push_back(16'hA5A5);
    tick();
    check_eq("rd_t1", {ale, ad_out}, {1'b1, 16'h4566});
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 3) ready = 1'b0;
      if (c == 6) ready = 1'b1;
      check_eq($sformatf("rd_c%0d", c), {eu_ack, rd_n, ad_oe}, 3'b000);
    end
    tick();
    check_eq("rd_t4", {eu_ack, rd_n}, 2'b11);
    check_eq("rd_data", eu_rdata, eu_q.pop_front());
    eu_req = 1'b0; rd_override = 1'b0;
    tick();
    check_eq("rd_hold", {eu_ack, eu_rdata}, {1'b0, 16'hA5A5});

    // EU request during prefetch T2 follows the prefetch T4 directly.
    pop_check("pop_a"); pop_check("pop_b");
    wait_ale("pf_fff6", 4);
    check_eq("pf_fff6_addr", ad_out, 16'hFFF6);
    push_word(16'hFFF6);
    tick();
    eu_req = 1'b1; eu_we = 1'b1; eu_addr = 16'h0100; eu_wdata = 16'h1111;
    tick(); tick();
    check_eq("b2b_t4", {ale, eu_ack}, 2'b00);
    tick();
    check_eq("b2b_eu_t1", {ale, ad_out}, {1'b1, 16'h0100});
    tick(); tick(); tick();
    check_eq("b2b_ack", eu_ack, 1'b1);
    eu_req = 1'b0;

    // Flush during prefetch T3 drops its data and restarts at an odd address.
    pop_check("pop_c"); pop_check("pop_d");
    wait_ale("pf_fff8", 4);
    check_eq("pf_fff8_addr", ad_out, 16'hFFF8);
    tick(); tick();
    flush = 1'b1; flush_addr = 16'h2001;
    tick();
    flush = 1'b0;
    check_eq("flush_empty", {q_valid, q_byte}, 9'h000);
    exp_q.delete();
    push_word(16'h2001);
    tick();
    check_eq("flush_t1", {ale, ad_out}, {1'b1, 16'h2000});
    wait_ale("pf_2002", 8);
    check_eq("pf_2002_addr", ad_out, 16'h2002);
    pop_check("pop_2001");
    push_word(16'h2002); push_word(16'h2004); push_word(16'h2006);
    repeat (20) tick();

    // Pop and push on the same edge at count 3, then drain with the bus stalled.
    flush = 1'b1; flush_addr = 16'h3001;
    tick();
    flush = 1'b0;
    exp_q.delete();
    push_word(16'h3001); push_word(16'h3002); push_word(16'h3004);
    wait_ale("pf_3000", 8);
    wait_ale("pf_3002", 8);
    wait_ale("pf_3004", 8);
    check_eq("pf_3004_addr", ad_out, 16'h3004);
    tick(); tick();
    pop_check("pop_same_edge");
    ready = 1'b0;
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
    check_eq("drained", {q_valid, q_byte}, 9'h000);
    q_pop = 1'b1;
    tick();
    q_pop = 1'b0;
    check_eq("pop_empty", q_valid, 1'b0);
    push_word(16'h3006);
    ready = 1'b1;
    k = 0;
    while (!q_valid && k < 10) begin
      tick();
      k++;
    end
    pop_check("after_empty_pop");

    // Asynchronous reset in the middle of a read cycle.
    eu_req = 1'b1; eu_we = 1'b0; eu_addr = 16'h5000;
    k = 0;
    do begin
      tick();
      k++;
    end while (rd_n && k < 12);
    check_eq("pre_rst_rd", rd_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst", {rd_n, wr_n, ad_oe, ale, q_valid}, 5'b11000);
    eu_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
